// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, phase constants and default timing for the spi_ctrl link.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, TX_START, TX_END, GAP1, RX_START, RX_END, CHECK, ABORT} state_t;
  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;
  localparam int TIMER_W = 20;
  localparam int SPI_CLK_DIV = 200;
  localparam int GAP_CYCLES_DEF = 5 * SPI_CLK_DIV;
  localparam int TIMEOUT_CYCLES_DEF = 65535;
  localparam int RETRY_MAX_DEF = 3;
  localparam int AUTO_PERIOD_DEF = 5000000;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_link_sequencer.sv
// spi_link_sequencer: write-then-read handshake sequencer for spi_ctrl with retry,
// per-state timeout abort and link health reporting.
module spi_link_sequencer
  import spi_pkg::*;
#(
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int RETRY_MAX      = RETRY_MAX_DEF,
  parameter int AUTO_PERIOD    = AUTO_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       auto_mode,
  input  logic       cs_n,
  input  logic       receive_status,
  output logic       spi_tx_en,
  output logic       spi_rx_en,
  output logic       mode_select,
  output logic       busy,
  output logic       link_ok,
  output logic [7:0] err_count,
  output logic       timeout_flag
);
  localparam int AW = $clog2(AUTO_PERIOD + 1);
  state_t state, state_d;
  logic [TIMER_W-1:0] timer;
  logic [AW-1:0] auto_timer;
  logic [2:0] retry;
  logic rs_s, launch, timed_out, gap_done, pass, fail, retry_ok;

  sync_2ff u_rs_sync (.clk(clk), .rst_n(rst_n), .d(receive_status), .q(rs_s));

  assign launch = start || (auto_mode && auto_timer == AW'(AUTO_PERIOD - 1));
  assign timed_out = timer == TIMER_W'(TIMEOUT_CYCLES - 1);
  assign gap_done = timer == TIMER_W'(GAP_CYCLES - 1);
  assign pass = state == CHECK && rs_s;
  assign fail = (state == CHECK && !rs_s) || (state == ABORT && gap_done);
  assign retry_ok = retry < 3'(RETRY_MAX);
  assign busy = state != IDLE;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = launch ? TX_START : IDLE;
      TX_START: state_d = !cs_n ? TX_END : timed_out ? ABORT : TX_START;
      TX_END:   state_d = cs_n ? GAP1 : timed_out ? ABORT : TX_END;
      GAP1:     state_d = gap_done ? RX_START : GAP1;
      RX_START: state_d = !cs_n ? RX_END : timed_out ? ABORT : RX_START;
      RX_END:   state_d = cs_n ? CHECK : timed_out ? ABORT : RX_END;
      CHECK:    state_d = (rs_s || !retry_ok) ? IDLE : TX_START;
      ABORT:    state_d = gap_done ? (retry_ok ? TX_START : IDLE) : ABORT;
      default:  state_d = IDLE;
    endcase
  end

  // Enables and mode are registered from the next state so they switch cleanly with it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      auto_timer   <= '0;
      retry        <= '0;
      err_count    <= '0;
      link_ok      <= 1'b0;
      timeout_flag <= 1'b0;
      spi_tx_en    <= 1'b0;
      spi_rx_en    <= 1'b0;
      mode_select  <= MODE_TX;
    end else begin
      state        <= state_d;
      timer        <= state_d != state ? '0 : timer + 1'b1;
      auto_timer   <= (state == IDLE && state_d == IDLE && auto_mode) ? auto_timer + 1'b1 : '0;
      retry        <= (pass || (fail && !retry_ok)) ? '0 : fail ? retry + 1'b1 : retry;
      err_count    <= fail ? sat_inc(err_count) : err_count;
      link_ok      <= pass ? 1'b1 : (fail && !retry_ok) ? 1'b0 : link_ok;
      timeout_flag <= state_d == ABORT ? 1'b1 : (state == IDLE && start) ? 1'b0 : timeout_flag;
      spi_tx_en    <= state_d == TX_START || state_d == TX_END;
      spi_rx_en    <= state_d == RX_START || state_d == RX_END;
      mode_select  <= state_d == TX_START ? MODE_TX : state_d == RX_START ? MODE_RX : mode_select;
    end
endmodule

// File: tb/tb_spi_link_sequencer.sv
// tb_spi_link_sequencer: randomized scoreboard bench with a behavioural spi_ctrl/cs_n model.
module tb_spi_link_sequencer;
  localparam int GAP = 10, TMO = 50, RMAX = 2, AUTO = 200, TX_HOLD = 24;

  typedef struct {
    int         txs;
    int         rxs;
    logic       link;
    logic [7:0] err;
    logic       tflag;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, auto_mode = 1'b0, cs_n = 1'b1;
  logic receive_status;
  logic spi_tx_en, spi_rx_en, mode_select, busy, link_ok, timeout_flag;
  logic [7:0] err_count;

  exp_t exp_q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;
  int tx_total = 0, rx_total = 0, tx_len = 0, gap_len = 0, overlap = 0, done_count = 0;
  int tx_at = 0, rx_at = 0, ov_at = 0, base = 0, cs_cnt = 0;
  logic tx_q = 1'b0, rx_q = 1'b0, busy_q = 1'b0, hung = 1'b0, by_start = 1'b0;
  logic [7:0] rs_plan = 8'd0;
  logic [2:0] idx;
  int m_err = 0;
  logic m_link = 1'b0, m_tflag = 1'b0;

  always #5 clk = ~clk;

  assign idx = 3'(tx_total - base - 1);
  assign receive_status = rs_plan[idx];

  spi_link_sequencer #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX), .AUTO_PERIOD(AUTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_mode(auto_mode), .cs_n(cs_n),
    .receive_status(receive_status), .spi_tx_en(spi_tx_en), .spi_rx_en(spi_rx_en),
    .mode_select(mode_select), .busy(busy), .link_ok(link_ok), .err_count(err_count),
    .timeout_flag(timeout_flag)
  );

  // Slave side: cs_n falls 3 cycles after an enable and rises 20 cycles later; a hung slave never answers.
  always @(posedge clk)
    if (!(spi_tx_en || spi_rx_en)) begin
      cs_cnt <= 0;
      cs_n   <= 1'b1;
    end else if (!hung) begin
      cs_cnt <= cs_cnt + 1;
      cs_n   <= !(cs_cnt >= 2 && cs_cnt < 22);
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  always @(negedge clk) begin
    if (busy && !busy_q) begin
      tx_at = tx_total;
      rx_at = rx_total;
      ov_at = overlap;
      if (by_start) chk("tflag_cleared_by_start", timeout_flag, 0);
    end
    if (spi_tx_en && spi_rx_en) overlap++;
    if (spi_tx_en && !tx_q) begin
      tx_total++;
      chk("tx_mode", mode_select, 0);
    end
    tx_len = spi_tx_en ? (tx_q ? tx_len + 1 : 1) : tx_len;
    if (!spi_tx_en && tx_q && rst_n) begin
      chk("tx_hold", tx_len, hung ? TMO : TX_HOLD);
      if (hung) chk("abort_tflag", timeout_flag, 1);
    end
    gap_len = (!spi_tx_en && tx_q) ? 1 : (!spi_tx_en && !spi_rx_en) ? gap_len + 1 : gap_len;
    if (spi_rx_en && !rx_q) begin
      rx_total++;
      chk("rx_mode", mode_select, 1);
      chk("gap_len", gap_len, GAP);
    end
    if (!busy && busy_q && rst_n) begin
      if (exp_q.size() == 0) fail_now("unexpected_cycle_end");
      else begin
        mon_e = exp_q.pop_front();
        chk("link_ok", link_ok, mon_e.link);
        chk("err_count", err_count, mon_e.err);
        chk("timeout_flag", timeout_flag, mon_e.tflag);
        chk("tx_count", tx_total - tx_at, mon_e.txs);
        chk("rx_count", rx_total - rx_at, mon_e.rxs);
        chk("enable_overlap", overlap - ov_at, 0);
      end
      done_count++;
    end
    tx_q = spi_tx_en;
    rx_q = spi_rx_en;
    busy_q = busy;
  end

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_count == d0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_count == d0) fail_now("cycle_done_timeout");
  endtask

  // Reference: attempts stop at the first passing one or after RETRY_MAX+1; every failed attempt costs one error.
  task automatic run(input logic [7:0] plan, input logic h, input logic use_start);
    exp_t e;
    int att = 0, n = 0, d0;
    logic passed = 1'b0;
    for (int i = 0; i <= RMAX && !passed; i++) begin
      att++;
      passed = !h && plan[i];
    end
    m_err += att - (passed ? 1 : 0);
    if (m_err > 255) m_err = 255;
    m_link = passed;
    m_tflag = (use_start ? 1'b0 : m_tflag) | h;
    e = '{att, h ? 0 : att, m_link, 8'(m_err), m_tflag};
    exp_q.push_back(e);
    rs_plan = plan;
    hung = h;
    base = tx_total;
    by_start = use_start;
    d0 = done_count;
    if (use_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      auto_mode = 1'b1;
      do begin
        @(negedge clk);
        n++;
      end while (!spi_tx_en && n < 1000);
      chk("auto_launch_delay", n, AUTO);
      repeat (3) begin
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_done(d0);
    auto_mode = 1'b0;
  endtask

  initial begin
    int n;
    #1;
    chk("rst_tx_en", spi_tx_en, 0);
    chk("rst_rx_en", spi_rx_en, 0);
    chk("rst_mode", mode_select, 0);
    chk("rst_busy", busy, 0);
    chk("rst_link_ok", link_ok, 0);
    chk("rst_err", err_count, 0);
    chk("rst_tflag", timeout_flag, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(8'b001, 1'b0, 1'b1);
    run(8'b010, 1'b0, 1'b1);
    run(8'b000, 1'b0, 1'b1);
    run(8'b001, 1'b1, 1'b1);
    run(8'b001, 1'b0, 1'b1);
    repeat (8) run(8'($urandom_range(0, 7)), $urandom_range(0, 4) == 0, 1'b1);
    run(8'b001, 1'b0, 1'b0);
    while (m_err < 255) run(8'b000, 1'b0, 1'b1);
    run(8'b000, 1'b0, 1'b1);
    rs_plan = 8'b001;
    hung = 1'b0;
    base = tx_total;
    by_start = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(spi_rx_en && !cs_n) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rx_end", spi_rx_en && !cs_n, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rx_en", spi_rx_en, 0);
    chk("async_rst_tx_en", spi_tx_en, 0);
    chk("async_rst_mode", mode_select, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_link_ok", link_ok, 0);
    chk("async_rst_err", err_count, 0);
    chk("async_rst_tflag", timeout_flag, 0);
    m_err = 0;
    m_link = 1'b0;
    m_tflag = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = tx_total;
    repeat (40) @(negedge clk);
    chk("idle_after_reset_tx", tx_total - n, 0);
    chk("idle_after_reset_busy", busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
